// File: rtl/stack_pkg.sv
// Shared stack definitions: op-decode enum and error codes.
// Imported by param_stack and by the control unit that reads its flags.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } op_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;

    function automatic op_e decode_op(input logic push, input logic pop);
        op_e op;
        unique case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPL;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Storage below top-of-stack: WIDTH x (DEPTH-1) words, one sync write port,
// one async read port. Ports: clk, we_i/waddr_i/wdata_i, raddr_i -> rdata_o.
module stack_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-2];

    // Contents are never reset; entries above the live region are don't-care.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with registered top-of-stack, count and sticky flags.
// Ports: clk, rst_n, dado/push/pop/clr_err in; saida/nivel/vazio/cheio/ovrflw/undrflw out.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dado,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] saida,
    output logic [CW-1:0]    nivel,
    output logic             vazio,
    output logic             cheio,
    output logic             ovrflw,
    output logic             undrflw
);

    localparam int AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [CW-1:0]    nivel_q, nivel_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_set, unf_set;
    logic             we;
    logic [CW-1:0]    nm1, nm2;
    logic [AW-1:0]    waddr, raddr;
    logic [WIDTH-1:0] rdata;
    logic             empty, full;
    op_e              op;

    assign empty = (nivel_q == '0);
    assign full  = (nivel_q == CW'(DEPTH));
    assign op    = decode_op(push, pop);

    // Old top lands at mem[nivel-1]; entry under top is mem[nivel-2].
    // Addresses are forced to 0 when they would underflow.
    assign nm1   = nivel_q - CW'(1);
    assign nm2   = nivel_q - CW'(2);
    assign waddr = empty ? '0 : AW'(nm1);
    assign raddr = (nivel_q >= CW'(2)) ? AW'(nm2) : '0;

    stack_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (we),
        .waddr_i(waddr),
        .wdata_i(tos_q),
        .raddr_i(raddr),
        .rdata_o(rdata)
    );

    always_comb begin
        tos_d   = tos_q;
        nivel_d = nivel_q;
        we      = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            OP_PUSH: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    we      = !empty;
                    tos_d   = dado;
                    nivel_d = nivel_q + CW'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    tos_d   = (nivel_q >= CW'(2)) ? rdata : '0;
                    nivel_d = nm1;
                end
            end
            OP_REPL: begin
                // Replace-top; on an empty stack it degrades to a push
                // but still reports the refused pop half.
                tos_d = dado;
                if (empty) begin
                    nivel_d = CW'(1);
                    unf_set = 1'b1;
                end
            end
            default: ;
        endcase
        // A set in the same cycle as clear wins.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q   <= '0;
            nivel_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nivel_q <= nivel_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign saida   = tos_q;
    assign nivel   = nivel_q;
    assign vazio   = empty;
    assign cheio   = full;
    assign ovrflw  = ovf_q;
    assign undrflw = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH=16 and DEPTH=2 instances).
// Reference stack model feeds an expectation queue popped after each edge.
module tb_param_stack;

    logic        clk;
    logic        rst_n;
    logic [31:0] dado;
    logic        push, pop, clr_err;
    logic [31:0] saida;
    logic [4:0]  nivel;
    logic        vazio, cheio, ovrflw, undrflw;

    logic [31:0] dado2;
    logic        push2, pop2, clr2;
    logic [31:0] saida2;
    logic [1:0]  nivel2;
    logic        vazio2, cheio2, ovf2, unf2;

    param_stack #(.WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .dado(dado), .push(push), .pop(pop),
        .clr_err(clr_err), .saida(saida), .nivel(nivel), .vazio(vazio),
        .cheio(cheio), .ovrflw(ovrflw), .undrflw(undrflw)
    );

    param_stack #(.WIDTH(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .dado(dado2), .push(push2), .pop(pop2),
        .clr_err(clr2), .saida(saida2), .nivel(nivel2), .vazio(vazio2),
        .cheio(cheio2), .ovrflw(ovf2), .undrflw(unf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] saida;
        logic [4:0]  nivel;
        logic        vazio, cheio, ovf, unf;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m[$];
    logic        movf, munf;
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_state();
        exp_t e;
        e.saida = (m.size() == 0) ? 32'h0 : m[m.size()-1];
        e.nivel = 5'(m.size());
        e.vazio = (m.size() == 0);
        e.cheio = (m.size() == 16);
        e.ovf   = movf;
        e.unf   = munf;
        return e;
    endfunction

    task automatic model_op(input logic pu, input logic po,
                            input logic cl, input logic [31:0] d);
        if (cl) begin
            movf = 1'b0;
            munf = 1'b0;
        end
        if (pu && po) begin
            if (m.size() == 0) begin
                m.push_back(d);
                munf = 1'b1;
            end else begin
                m[m.size()-1] = d;
            end
        end else if (pu) begin
            if (m.size() == 16) movf = 1'b1;
            else m.push_back(d);
        end else if (po) begin
            if (m.size() == 0) munf = 1'b1;
            else void'(m.pop_back());
        end
    endtask

    task automatic step(input string tag, input logic pu, input logic po,
                        input logic cl, input logic [31:0] d);
        exp_t e;
        push = pu; pop = po; clr_err = cl; dado = d;
        model_op(pu, po, cl, d);
        exp_q.push_back(model_state());
        @(posedge clk);
        #1;
        push = 0; pop = 0; clr_err = 0;
        e = exp_q.pop_front();
        chk({tag, ".saida"}, 64'(saida), 64'(e.saida));
        chk({tag, ".nivel"}, 64'(nivel), 64'(e.nivel));
        chk({tag, ".vazio"}, 64'(vazio), 64'(e.vazio));
        chk({tag, ".cheio"}, 64'(cheio), 64'(e.cheio));
        chk({tag, ".ovf"}, 64'(ovrflw), 64'(e.ovf));
        chk({tag, ".unf"}, 64'(undrflw), 64'(e.unf));
    endtask

    task automatic step2(input logic pu, input logic po, input logic [31:0] d);
        push2 = pu; pop2 = po; dado2 = d;
        @(posedge clk);
        #1;
        push2 = 0; pop2 = 0;
    endtask

    initial begin
        rst_n = 0; push = 0; pop = 0; clr_err = 0; dado = 0;
        push2 = 0; pop2 = 0; clr2 = 0; dado2 = 0;
        movf = 0; munf = 0;
        #3;
        chk("rst.saida", 64'(saida), 64'h0);
        chk("rst.nivel", 64'(nivel), 64'h0);
        chk("rst.vazio", 64'(vazio), 64'h1);
        chk("rst.cheio", 64'(cheio), 64'h0);
        chk("rst.flags", 64'({ovrflw, undrflw}), 64'h0);
        #9 rst_n = 1;
        @(posedge clk); #1;

        step("p0", 1, 0, 0, 32'hA);
        chk("p0.top", 64'(saida), 64'hA);
        step("p1", 1, 0, 0, 32'hB);
        chk("p1.top", 64'(saida), 64'hB);
        step("p2", 1, 0, 0, 32'hC);
        chk("p2.top", 64'(saida), 64'hC);
        chk("p2.nivel", 64'(nivel), 64'd3);
        for (int i = 0; i < 3; i++) step("e", 0, 1, 0, 0);

        for (int i = 1; i <= 16; i++) step("fill", 1, 0, 0, 32'(i));
        step("ovf", 1, 0, 0, 32'h99);
        chk("ovf.cheio", 64'(cheio), 64'h1);
        chk("ovf.top", 64'(saida), 64'd16);
        chk("ovf.flag", 64'(ovrflw), 64'h1);
        step("clr", 0, 0, 1, 0);
        chk("clr.flags", 64'({ovrflw, undrflw}), 64'h0);
        step("replfull", 1, 1, 0, 32'h55);
        chk("replfull.ovf", 64'(ovrflw), 64'h0);
        step("clrovf", 1, 0, 1, 32'h98);
        chk("clrovf.ovf", 64'(ovrflw), 64'h1);
        step("pf0", 0, 1, 0, 0);
        chk("pf0.top", 64'(saida), 64'd15);
        for (int i = 0; i < 15; i++) step("drain", 0, 1, 0, 0);

        step("d5", 1, 0, 1, 32'd5);
        step("d7", 1, 0, 0, 32'd7);
        step("dp0", 0, 1, 0, 0);
        step("dp1", 0, 1, 0, 0);
        step("dp2", 0, 1, 0, 0);
        chk("dp2.unf", 64'(undrflw), 64'h1);
        chk("dp2.nivel", 64'(nivel), 64'h0);

        step("r1", 1, 0, 1, 32'd1);
        step("r2", 1, 0, 0, 32'd2);
        step("rr", 1, 1, 0, 32'h33);
        chk("rr.top", 64'(saida), 64'h33);
        step("rp", 0, 1, 0, 0);
        chk("rp.top", 64'(saida), 64'h1);
        step("rp2", 0, 1, 0, 0);
        step("re", 1, 1, 0, 32'h44);
        chk("re.nivel", 64'(nivel), 64'd1);
        chk("re.unf", 64'(undrflw), 64'h1);

        for (int i = 0; i < 4; i++) step("a", 1, 0, 0, 32'(100 + i));
        chk("a.nivel", 64'(nivel), 64'd5);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("arst.saida", 64'(saida), 64'h0);
        chk("arst.nivel", 64'(nivel), 64'h0);
        chk("arst.flags", 64'({ovrflw, undrflw}), 64'h0);
        m.delete(); movf = 0; munf = 0;
        #1 rst_n = 1;
        step("post", 1, 0, 0, 32'h77);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(0, 3));
            step("rnd", r[0], r[1], ($urandom_range(0, 7) == 0), $urandom);
        end

        step2(1, 0, 32'h11);
        step2(1, 0, 32'h22);
        chk("d2.full", 64'({cheio2, nivel2}), 64'({1'b1, 2'd2}));
        step2(1, 0, 32'h33);
        chk("d2.ovf", 64'(ovf2), 64'h1);
        chk("d2.top", 64'(saida2), 64'h22);
        step2(0, 1, 0);
        chk("d2.pop", 64'(saida2), 64'h11);
        step2(0, 1, 0);
        chk("d2.empty", 64'({vazio2, saida2}), 64'({1'b1, 32'h0}));
        step2(0, 1, 0);
        chk("d2.unf", 64'(unf2), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
